// File: rtl/mips_mem_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_MEM
    } owner_t;

endpackage

// File: rtl/mem_align_check.sv
// Flags word accesses off a 4-byte boundary and halfword accesses off a 2-byte boundary.
// Only built when MEM_ARB_ALIGN_CHECK_EN is defined.
`ifdef MEM_ARB_ALIGN_CHECK_EN
module mem_align_check
    import mips_mem_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_addr_lo,
    output logic       o_misaligned
);

    always_comb begin
        o_misaligned = 1'b0;
        if (i_size == SIZE_WORD) begin
            o_misaligned = (i_addr_lo != 2'b00);
        end else if (i_size == SIZE_HALF) begin
            o_misaligned = i_addr_lo[0];
        end
    end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between IF fetch and MEM load/store, MEM-first with starvation guard.
// Define MEM_ARB_ALIGN_CHECK_EN to trap misaligned accesses without touching the memory.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_rw,
    input  logic [1:0]        mem_size,
    input  logic              mem_se,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    output logic              mem_err,
    output logic [ADDR_W-1:0] m_A,
    output logic [DATA_W-1:0] m_DI,
    output logic [1:0]        m_Size,
    output logic              m_R_W,
    output logic              m_E,
    output logic              m_SE,
    input  logic [DATA_W-1:0] m_DO
);

    localparam int unsigned ST_W = $clog2(STARVE_MAX + 2);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    owner_t          r_owner;
    logic [2:0]      r_wait_cnt;
    logic [ST_W-1:0] r_starve_cnt;
    logic            w_any_req;
    logic            w_starved;
    logic            w_grant_mem;
    logic            w_misaligned;

    always_comb begin
        w_any_req   = if_req || mem_req;
        w_starved   = if_req && (r_starve_cnt == ST_W'(STARVE_MAX));
        w_grant_mem = mem_req && !w_starved;
    end

`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic [1:0] w_chk_size;
    logic [1:0] w_chk_lo;
    logic       r_err;

    assign w_chk_size = w_grant_mem ? mem_size : SIZE_WORD;
    assign w_chk_lo   = w_grant_mem ? mem_addr[1:0] : if_addr[1:0];

    mem_align_check u_align_check (
        .i_size       (w_chk_size),
        .i_addr_lo    (w_chk_lo),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (r_state == IDLE && w_any_req) begin
            r_err <= w_misaligned;
        end
    end

    assign mem_err = mem_done && r_err;
`else
    assign w_misaligned = 1'b0;
    assign mem_err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = w_misaligned ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (r_wait_cnt == '0) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        m_E       = (r_state == ACCESS);
        if_done   = (r_state == RESP) && (r_owner == OWN_IF);
        mem_done  = (r_state == RESP) && (r_owner == OWN_MEM);
        if_stall  = if_req && !if_done;
        mem_stall = mem_req && !mem_done;
    end

    // Counter only moves in IDLE; it saturates so a long MEM burst cannot wrap it past the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (!if_req) begin
                r_starve_cnt <= '0;
            end else if (w_grant_mem) begin
                if (r_starve_cnt != ST_W'(STARVE_MAX)) begin
                    r_starve_cnt <= r_starve_cnt + ST_W'(1);
                end
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= OWN_IF;
            r_wait_cnt <= '0;
            m_A        <= '0;
            m_DI       <= '0;
            m_Size     <= '0;
            m_R_W      <= 1'b0;
            m_SE       <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_wait_cnt <= 3'(WAIT_CYCLES);
                        if (w_grant_mem) begin
                            r_owner <= OWN_MEM;
                            m_A     <= mem_addr;
                            m_DI    <= mem_wdata;
                            m_Size  <= mem_size;
                            m_R_W   <= mem_rw;
                            m_SE    <= mem_se;
                        end else begin
                            r_owner <= OWN_IF;
                            m_A     <= if_addr;
                            m_DI    <= '0;
                            m_Size  <= SIZE_WORD;
                            m_R_W   <= 1'b0;
                            m_SE    <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end else if (!m_R_W) begin
                        if (r_owner == OWN_MEM) begin
                            mem_rdata <= m_DO;
                        end else begin
                            if_rdata <= m_DO;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expectations, a negedge monitor pops and compares.
// Define MEM_ARB_ALIGN_CHECK_EN to also exercise the misalignment trap.
module tb_mem_port_arbiter;
    import mips_mem_pkg::*;

    localparam int unsigned AW   = 9;
    localparam int unsigned DW   = 32;
    localparam int unsigned W    = 1;
    localparam int unsigned SMAX = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_done, if_stall;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          mem_req, mem_rw, mem_se, mem_done, mem_stall, mem_err;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [AW-1:0] m_A;
    logic [DW-1:0] m_DI, m_DO;
    logic [1:0]    m_Size;
    logic          m_R_W, m_E, m_SE;

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .WAIT_CYCLES (W),
        .STARVE_MAX  (SMAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .mem_req   (mem_req),
        .mem_rw    (mem_rw),
        .mem_size  (mem_size),
        .mem_se    (mem_se),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .mem_stall (mem_stall),
        .mem_err   (mem_err),
        .m_A       (m_A),
        .m_DI      (m_DI),
        .m_Size    (m_Size),
        .m_R_W     (m_R_W),
        .m_E       (m_E),
        .m_SE      (m_SE),
        .m_DO      (m_DO)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct { logic [31:0] data; logic err; int dcyc; } exp_t;
    typedef struct { logic [AW-1:0] a; logic [1:0] sz; logic [31:0] d; } wr_t;

    exp_t        if_q[$];
    exp_t        mem_q[$];
    wr_t         wr_q[$];
    logic [31:0] if_last  = '0;
    logic [31:0] mem_last = '0;
    string       order;

    // Memory content: a fixed hash of the address, sized and extended like the real memory model.
    function automatic logic [31:0] mem_word(input logic [AW-1:0] a, input logic [1:0] sz, input logic se);
        logic [31:0] w;
        w = (32'(a) + 32'd1) * 32'h9E3779B9;
        case (sz)
            2'b00:   return se ? {{24{w[7]}}, w[7:0]} : {24'd0, w[7:0]};
            2'b01:   return se ? {{16{w[15]}}, w[15:0]} : {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        #2;
        m_DO = m_E ? mem_word(m_A, m_Size, m_SE) : $urandom;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic chk_s(input string nm, input string act, input string exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %s, required %s (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic fail(input string nm);
        n_chk++;
        $display("FAIL %s: no response, required a done pulse (cycle %0d)", nm, cyc);
    endtask

    task automatic if_fetch(input logic [AW-1:0] a, input int dcyc);
        exp_t e;
        int   n;
        logic mis;
        mis = 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        mis = (a[1:0] != 2'b00);
`endif
        if (!mis) if_last = mem_word(a, SIZE_WORD, 1'b0);
        e = '{if_last, 1'b0, dcyc};
        if_q.push_back(e);
        if_addr = a;
        if_req  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_done && n < 200);
        if (!if_done) fail("if_timeout");
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic mem_access(input logic rw, input logic [1:0] sz, input logic se,
                              input logic [AW-1:0] a, input logic [31:0] wd, input int dcyc);
        exp_t e;
        int   n;
        logic mis;
        mis = 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        mis = (sz == SIZE_WORD && a[1:0] != 2'b00) || (sz == SIZE_HALF && a[0]);
`endif
        if (!mis && !rw) mem_last = mem_word(a, sz, se);
        if (!mis && rw) wr_q.push_back('{a, sz, wd});
        e = '{mem_last, mis, dcyc};
        mem_q.push_back(e);
        mem_rw    = rw;
        mem_size  = sz;
        mem_se    = se;
        mem_addr  = a;
        mem_wdata = wd;
        mem_req   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_done && n < 200);
        if (!mem_done) fail("mem_timeout");
        @(posedge clk);
        #1;
        mem_req = 1'b0;
    endtask

    int                    e_run = 0;
    logic [AW+DW+4-1:0]    e_snap;

    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        if (reset) begin
            e_run = 0;
        end else begin
            if (if_done) begin
                order = {order, "I"};
                if (if_q.size() == 0) fail("if_done_unexpected");
                else begin
                    e = if_q.pop_front();
                    chk("if_rdata", if_rdata, e.data);
                    chk("if_stall_at_done", if_stall, 0);
                    if (e.dcyc >= 0) chk("if_done_cycle", cyc, e.dcyc);
                end
            end
            if (mem_done) begin
                order = {order, "M"};
                if (mem_q.size() == 0) fail("mem_done_unexpected");
                else begin
                    e = mem_q.pop_front();
                    chk("mem_rdata", mem_rdata, e.data);
                    chk("mem_err", mem_err, e.err);
                    if (e.dcyc >= 0) chk("mem_done_cycle", cyc, e.dcyc);
                end
            end
            if (m_E) begin
                if (e_run == 0) begin
                    e_snap = {m_A, m_DI, m_Size, m_R_W, m_SE};
                    if (m_R_W) begin
                        if (wr_q.size() == 0) fail("write_unexpected");
                        else begin
                            w = wr_q.pop_front();
                            chk("wr_addr", m_A, w.a);
                            chk("wr_size", m_Size, w.sz);
                            chk("wr_data", m_DI, w.d);
                        end
                    end
                end else begin
                    chk("m_stable", {m_A, m_DI, m_Size, m_R_W, m_SE}, e_snap);
                end
                e_run++;
            end else if (e_run != 0) begin
                chk("m_E_cycles", e_run, W + 1);
                e_run = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int    t;
        string exp_order;
        reset = 1'b1;
        if_req = 1'b1; if_addr = '0;
        mem_req = 1'b1; mem_rw = 1'b0; mem_size = SIZE_WORD; mem_se = 1'b0;
        mem_addr = '0; mem_wdata = '0;
        @(negedge clk);
        chk("rst_stalls_follow_req", {if_stall, mem_stall}, 2'b11);
        if_req = 1'b0;
        mem_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_outputs", {m_E, if_done, mem_done, mem_err, if_rdata, mem_rdata}, 0);
        chk("rst_mem_pins", {m_A, m_DI, m_Size, m_R_W, m_SE}, 0);
        chk("rst_stalls_idle", {if_stall, mem_stall}, 2'b00);
        @(posedge clk);
        #1;

        // Lone fetch: stall and m_E windows by cycle.
        t = cyc;
        fork
            if_fetch(9'h004, t + W + 2);
            for (int k = 0; k <= W + 2; k++) begin
                @(negedge clk);
                chk("lone_if_stall", if_stall, k <= W + 1);
                chk("lone_if_mE", m_E, (k >= 1) && (k <= W + 1));
            end
        join

        // Simultaneous requests: MEM first, IF afterwards.
        t = cyc;
        fork
            mem_access(1'b0, SIZE_WORD, 1'b0, 9'h010, 32'h0, t + W + 2);
            if_fetch(9'h008, t + 2 * W + 5);
        join

        // Starvation guard, run twice to show the counter is cleared between bursts.
        exp_order = "";
        for (int k = 0; k < SMAX; k++) exp_order = {exp_order, "M"};
        exp_order = {exp_order, "IM"};
        for (int rep = 0; rep < 2; rep++) begin
            order = "";
            fork
                if_fetch(9'h00C, -1);
                for (int k = 0; k < SMAX + 1; k++)
                    mem_access(1'b0, SIZE_WORD, 1'b0, 9'(32 + 4 * k), 32'h0, -1);
            join
            chk_s("starve_order", order, exp_order);
        end

        // Byte store: pins carry the raw fields, load data holds.
        t = cyc;
        mem_access(1'b1, SIZE_BYTE, 1'b0, 9'h021, 32'h0000_00AB, t + W + 2);

        // Reset during the second ACCESS cycle.
        t = cyc;
        mem_rw = 1'b0; mem_size = SIZE_WORD; mem_se = 1'b0; mem_addr = 9'h040;
        mem_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_pre_mE", m_E, 1);
        reset = 1'b1;
        mem_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_mE", m_E, 0);
        chk("rst_mid_done", mem_done, 0);
        chk("rst_mid_rdata", {mem_rdata, if_rdata}, 0);
        mem_last = '0;
        if_last  = '0;
        repeat (4) @(posedge clk);
        #1;

`ifdef MEM_ARB_ALIGN_CHECK_EN
        t = cyc;
        fork
            mem_access(1'b0, SIZE_WORD, 1'b0, 9'h002, 32'h0, t + 1);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("misalign_mE", m_E, 0);
            end
        join
        t = cyc;
        if_fetch(9'h006, t + 1);
        t = cyc;
        mem_access(1'b0, SIZE_HALF, 1'b1, 9'h013, 32'h0, t + 1);
`endif

        // Randomized mixed traffic.
        fork
            for (int k = 0; k < 60; k++) begin
                int            gap;
                logic [AW-1:0] a;
                gap = $urandom_range(0, 3);
                repeat (gap) begin @(posedge clk); #1; end
                a = AW'($urandom);
                a[1:0] = 2'b00;
                if_fetch(a, -1);
            end
            for (int k = 0; k < 60; k++) begin
                int            gap;
                logic [AW-1:0] a;
                logic [1:0]    sz;
                gap = $urandom_range(0, 3);
                repeat (gap) begin @(posedge clk); #1; end
                sz = 2'($urandom_range(0, 2));
                a  = AW'($urandom);
`ifdef MEM_ARB_ALIGN_CHECK_EN
                if ($urandom_range(0, 7) != 0) begin
`else
                begin
`endif
                    if (sz == SIZE_WORD) a[1:0] = 2'b00;
                    if (sz == SIZE_HALF) a[0] = 1'b0;
                end
                mem_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, -1);
            end
        join

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("if_q_drained", if_q.size(), 0);
        chk("mem_q_drained", mem_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
